adder_tree_acc: RTL and testbench

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

---
 rtl/adder_tree_pkg.sv | 32 +++
 rtl/adder_tree_stage.sv | 45 ++++
 rtl/adder_tree_acc.sv | 102 ++++++++++
 tb/tb_adder_tree_acc.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree accumulator.
// Provides the default accumulator headroom, a log2 helper and a signed clamp.
package adder_tree_pkg;

    localparam int ACC_EXTRA_BITS_DEFAULT = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: pairwise signed sums, one bit wider.
// Valid and last travel alongside the data; everything holds when en is low.
module adder_tree_stage import adder_tree_pkg::*; #(
    parameter int NUM_OPS  = 4,
    parameter int IN_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [NUM_OPS*IN_WIDTH-1:0]          operands,
    input  logic                                 valid,
    input  logic                                 last,
    output logic [(NUM_OPS/2)*(IN_WIDTH+1)-1:0]  sums,
    output logic                                 sum_valid,
    output logic                                 sum_last
);

    localparam int OW = IN_WIDTH + 1;

    logic [(NUM_OPS/2)*OW-1:0] pair;

    // Sign-extend each operand pair by one bit and add.
    always_comb begin
        pair = '0;
        for (int i = 0; i < NUM_OPS / 2; i++) begin
            pair[i*OW +: OW] =
                OW'($signed(operands[(2*i)*IN_WIDTH +: IN_WIDTH])) +
                OW'($signed(operands[(2*i+1)*IN_WIDTH +: IN_WIDTH]));
        end
    end

    // Register the level; bubbles pass through with valid low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sums      <= '0;
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
        end else if (en) begin
            sums      <= pair;
            sum_valid <= valid;
            sum_last  <= last;
        end
    end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined adder tree feeding a wrapping accumulator with rounded output.
// Define ADDER_TREE_ACC_SAT_EN to saturate the output instead of wrapping.
module adder_tree_acc import adder_tree_pkg::*; #(
    parameter int NUM_INPUTS     = 4,
    parameter int IN_WIDTH       = 8,
    parameter int ACC_EXTRA_BITS = ACC_EXTRA_BITS_DEFAULT,
    parameter int OUT_SCALE      = 0,
    parameter int OUT_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0]   in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic signed [OUT_WIDTH-1:0]      out_data,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int L         = clog2(NUM_INPUTS);
    localparam int SW        = IN_WIDTH + L;
    localparam int ACC_WIDTH = SW + ACC_EXTRA_BITS;
    localparam int BUS       = NUM_INPUTS * IN_WIDTH + L;
    localparam logic signed [63:0] RND =
        (OUT_SCALE > 0) ?
        (64'sd1 <<< ((OUT_SCALE > 0) ? OUT_SCALE - 1 : 0)) : 64'sd0;

    logic                        en;
    logic [BUS-1:0]              lvl_data [0:L];
    logic [L:0]                  lvl_valid;
    logic [L:0]                  lvl_last;
    logic signed [SW-1:0]        sum;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] total;
    logic signed [63:0]          wide;
    logic signed [63:0]          scaled;
    logic signed [OUT_WIDTH-1:0] result;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign lvl_data[0]  = BUS'(in_data);
    assign lvl_valid[0] = in_valid;
    assign lvl_last[0]  = in_last;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NK = NUM_INPUTS >> k;
        localparam int WK = IN_WIDTH + k;
        logic [(NK/2)*(WK+1)-1:0] q;

        adder_tree_stage #(
            .NUM_OPS  (NK),
            .IN_WIDTH (WK)
        ) u_stage (
            .clk       (clk),
            .rst_n     (arst_n_in),
            .en        (en),
            .operands  (lvl_data[k][NK*WK-1:0]),
            .valid     (lvl_valid[k]),
            .last      (lvl_last[k]),
            .sums      (q),
            .sum_valid (lvl_valid[k+1]),
            .sum_last  (lvl_last[k+1])
        );

        assign lvl_data[k+1] = BUS'(q);
    end

    assign sum    = lvl_data[L][SW-1:0];
    assign total  = acc + ACC_WIDTH'(sum);
    assign wide   = 64'(total);
    assign scaled = (wide + RND) >>> OUT_SCALE;

`ifdef ADDER_TREE_ACC_SAT_EN
    logic signed [63:0] clamped;
    assign clamped = sat_clamp(scaled, OUT_WIDTH);
    assign result  = clamped[OUT_WIDTH-1:0];
`else
    assign result  = scaled[OUT_WIDTH-1:0];
`endif

    // Accumulate valid beats; a last beat emits the result and restarts.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= lvl_valid[L] && lvl_last[L];
            if (lvl_valid[L]) begin
                if (lvl_last[L]) begin
                    out_data <= result;
                    acc      <= '0;
                end else begin
                    acc      <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: default, scaled and narrow instances.
// Narrow-output expectations follow ADDER_TREE_ACC_SAT_EN when defined.
module tb_adder_tree_acc;

    logic              clk;
    logic              rst_n;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_last;
    logic              out_ready;
    logic              rdy_d;
    logic              rdy_s;
    logic              rdy_n;
    logic signed [15:0] od_d;
    logic signed [15:0] od_s;
    logic signed [7:0]  od_n;
    logic              ov_d;
    logic              ov_s;
    logic              ov_n;

    int checks;
    int failures;

    adder_tree_acc dut_d (
        .clk(clk), .arst_n_in(rst_n), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_d),
        .out_data(od_d), .out_valid(ov_d), .out_ready(out_ready)
    );

    adder_tree_acc #(.OUT_SCALE(2)) dut_s (
        .clk(clk), .arst_n_in(rst_n), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_s),
        .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready)
    );

    adder_tree_acc #(.OUT_WIDTH(8)) dut_n (
        .clk(clk), .arst_n_in(rst_n), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_n),
        .out_data(od_n), .out_valid(ov_n), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int e_def;
        int e_scl;
        int e_wrap;
        int e_sat;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b, input int c, input int d,
                        input logic l);
        in_data  = {8'(d), 8'(c), 8'(b), 8'(a)};
        in_valid = 1'b1;
        in_last  = l;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        int e_nar;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();

        tbl[0] = '{1, 2, 3, 4, 10, 3, 10, 10};
        tbl[1] = '{-1, -2, -3, -4, -10, -2, -10, -10};
        tbl[2] = '{1, 1, 2, 2, 6, 2, 6, 6};
        tbl[3] = '{127, 127, 46, 0, 300, 75, 44, 127};
        tbl[4] = '{-128, -128, -44, 0, -300, -75, -44, -128};
        tbl[5] = '{-128, -128, -128, -128, -512, -128, 0, -128};
        tbl[6] = '{127, 127, 127, 127, 508, 127, -4, 127};

        tick();
        tick();
        check("rst_out_valid", int'(ov_d), 0);
        check("rst_out_data", int'(od_d), 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", int'(rdy_d), 1);

        for (int i = 0; i < 7; i++) begin
            beat(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 1'b1);
            tick();
            idle();
            check("vec_valid_e1", int'(ov_d), 0);
            tick();
            check("vec_valid_e2", int'(ov_d), 0);
            tick();
            check("vec_valid_e3", int'(ov_d), 1);
            check("vec_def", int'(od_d), tbl[i].e_def);
            check("vec_scl", int'(od_s), tbl[i].e_scl);
`ifdef ADDER_TREE_ACC_SAT_EN
            e_nar = tbl[i].e_sat;
`else
            e_nar = tbl[i].e_wrap;
`endif
            check("vec_nar", int'(od_n), e_nar);
            tick();
            check("vec_valid_e4", int'(ov_d), 0);
        end

        beat(-128, -128, -128, -128, 1'b0);
        tick();
        beat(-128, -128, -128, -128, 1'b0);
        tick();
        beat(127, 127, 127, 127, 1'b1);
        tick();
        beat(1, 1, 1, 1, 1'b1);
        tick();
        idle();
        check("multi_valid_pre", int'(ov_d), 0);
        tick();
        check("multi_valid", int'(ov_d), 1);
        check("multi_data", int'(od_d), -516);
        tick();
        check("next_valid", int'(ov_d), 1);
        check("next_data", int'(od_d), 4);
        tick();
        check("next_clear", int'(ov_d), 0);

        beat(1, 0, 0, 0, 1'b1);
        tick();
        beat(2, 0, 0, 0, 1'b1);
        tick();
        beat(3, 0, 0, 0, 1'b1);
        tick();
        check("bp_first_valid", int'(ov_d), 1);
        check("bp_first_data", int'(od_d), 1);
        out_ready = 1'b0;
        beat(4, 0, 0, 0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", int'(rdy_d), 0);
            tick();
            check("bp_hold_valid", int'(ov_d), 1);
            check("bp_hold_data", int'(od_d), 1);
        end
        out_ready = 1'b1;
        tick();
        idle();
        check("bp_r2_data", int'(od_d), 2);
        check("bp_r2_ready", int'(rdy_d), 1);
        tick();
        check("bp_r3_data", int'(od_d), 3);
        tick();
        check("bp_r4_valid", int'(ov_d), 1);
        check("bp_r4_data", int'(od_d), 4);
        tick();
        check("bp_done", int'(ov_d), 0);

        beat(7, 0, 0, 0, 1'b0);
        tick();
        beat(9, 0, 0, 0, 1'b0);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", int'(ov_d), 0);
        check("mid_rst_data", int'(od_d), 0);
        rst_n = 1'b1;
        tick();
        check("mid_rst_ready", int'(rdy_d), 1);
        beat(5, 0, 0, 0, 1'b1);
        tick();
        idle();
        tick();
        check("mid_rst_quiet", int'(ov_d), 0);
        tick();
        check("mid_rst_res_valid", int'(ov_d), 1);
        check("mid_rst_res_data", int'(od_d), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
